id_ex_stage: RTL and testbench

//  ID->EX pipeline register; sole source of operands and AluOp for the alu.

---
 rtl/id_ex_stage.sv | 147 ++++++++++++++
 tb/tb_id_ex_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: the alu's only source of operands and AluOp.
// Define ALU_FWD_EN for MEM/WB forwarding with a load-use bubble; otherwise incoming sources interlock.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int REGIDX_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          in_op,
    input  logic [REGIDX_W-1:0] in_rs1,
    input  logic [REGIDX_W-1:0] in_rs2,
    input  logic [XLEN-1:0]     in_rs1_val,
    input  logic [XLEN-1:0]     in_rs2_val,
    input  logic [XLEN-1:0]     in_imm,
    input  logic                in_use_imm,
    input  logic [REGIDX_W-1:0] in_rd,
    input  logic                in_wen,
    input  logic                flush,
    input  logic                ex_ready,
    input  logic                mem_wen,
    input  logic [REGIDX_W-1:0] mem_rd,
    input  logic [XLEN-1:0]     mem_val,
    input  logic                mem_is_load,
    input  logic                wb_wen,
    input  logic [REGIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]     wb_val,
    output logic                out_valid,
    output logic [2:0]          out_op,
    output logic [XLEN-1:0]     out_a,
    output logic [XLEN-1:0]     out_b,
    output logic [REGIDX_W-1:0] out_rd,
    output logic                out_wen
);
    localparam logic [2:0] OP_ADD = 3'd2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                   state_reg, state_next;
    logic [2:0]               op_reg;
    logic [1:0][XLEN-1:0]     opnd_reg;
    logic [1:0][REGIDX_W-1:0] src_reg;
    logic [1:0]               src_used_reg;
    logic [REGIDX_W-1:0]      rd_reg;
    logic                     wen_reg;

    logic [1:0][XLEN-1:0]     fwd_val;
    logic [1:0]               hazard_hit;
    logic                     full;
    logic                     hazard_stall;
    logic                     held_update;
    logic                     valid_int;
    logic                     fire_out;
    logic                     capture;

    assign full = (state_reg == FULL);

`ifdef ALU_FWD_EN
    logic [1:0] mem_hit;
    logic [1:0] wb_hit;

    // Operand 0 is rs1/a, operand 1 is rs2/b; index 0 (x0) never matches.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        assign mem_hit[gi] = full && src_used_reg[gi] && (src_reg[gi] != '0)
                             && mem_wen && (src_reg[gi] == mem_rd);
        assign wb_hit[gi]  = full && src_used_reg[gi] && (src_reg[gi] != '0)
                             && wb_wen && (src_reg[gi] == wb_rd);
        assign hazard_hit[gi] = mem_hit[gi] && mem_is_load;
        assign fwd_val[gi] = mem_hit[gi] ? mem_val
                           : (wb_hit[gi] ? wb_val : opnd_reg[gi]);
    end

    assign hazard_stall = |hazard_hit;
    assign valid_int    = full && !hazard_stall;
    // A bubbling load has no data yet, so nothing is latched until WB supplies it.
    assign held_update  = full && !fire_out && !hazard_stall;
`else
    logic [1:0][REGIDX_W-1:0] in_src;
    logic [1:0]               in_used;
    logic                     unused_nofwd;

    assign in_src  = {in_rs2, in_rs1};
    assign in_used = {!in_use_imm, 1'b1};

    // Hold off decode while any in-flight writer still owns an incoming source.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ilock
        assign hazard_hit[gi] = in_used[gi] && (in_src[gi] != '0)
            && ((valid_int && wen_reg && (in_src[gi] == rd_reg))
             || (mem_wen && (in_src[gi] == mem_rd))
             || (wb_wen  && (in_src[gi] == wb_rd)));
        assign fwd_val[gi] = opnd_reg[gi];
    end

    assign hazard_stall = |hazard_hit;
    assign valid_int    = full;
    assign held_update  = 1'b0;
    assign unused_nofwd = ^{mem_val, wb_val, mem_is_load, src_reg, src_used_reg};
`endif

    assign fire_out = valid_int && ex_ready;
    assign in_ready = (!full || fire_out) && !hazard_stall;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        state_next = state_reg;
        if (flush)
            state_next = EMPTY;
        else if (capture)
            state_next = FULL;
        else if (fire_out)
            state_next = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            op_reg       <= OP_ADD;
            opnd_reg     <= '0;
            src_reg      <= '0;
            src_used_reg <= '0;
            rd_reg       <= '0;
            wen_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                op_reg       <= in_op;
                opnd_reg[0]  <= in_rs1_val;
                opnd_reg[1]  <= in_use_imm ? in_imm : in_rs2_val;
                src_reg      <= {in_rs2, in_rs1};
                src_used_reg <= {!in_use_imm, 1'b1};
                rd_reg       <= in_rd;
                wen_reg      <= in_wen;
            end else if (held_update) begin
                // Keep forwarded values so they survive the producer retiring.
                opnd_reg <= fwd_val;
            end
        end
    end

    assign out_valid = valid_int;
    assign out_op    = op_reg;
    assign out_a     = fwd_val[0];
    assign out_b     = fwd_val[1];
    assign out_rd    = rd_reg;
    assign out_wen   = valid_int && wen_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, streaming, hold, flush and hazard handling.
// Hazard scenario chosen by ALU_FWD_EN (forward/load-use) or its absence (interlock).
module tb_id_ex_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_val, in_rs2_val, in_imm;
    logic        in_use_imm, in_wen;
    logic        flush, ex_ready;
    logic        mem_wen, mem_is_load, wb_wen;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_val, wb_val;
    logic        out_valid, out_wen;
    logic [2:0]  out_op;
    logic [31:0] out_a, out_b;
    logic [4:0]  out_rd;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.XLEN(32), .REGIDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wen(in_wen),
        .flush(flush), .ex_ready(ex_ready),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_val(mem_val), .mem_is_load(mem_is_load),
        .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_val(wb_val),
        .out_valid(out_valid), .out_op(out_op), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_wen(out_wen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; in_op = 3'd2; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_use_imm = 0; in_wen = 0;
        flush = 0; ex_ready = 1;
        mem_wen = 0; mem_rd = 0; mem_val = 0; mem_is_load = 0;
        wb_wen = 0; wb_rd = 0; wb_val = 0;
    endtask

    task automatic present(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           input logic use_imm, input logic [4:0] rd, input logic wen);
        in_valid = 1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rs1_val = a;
        in_rs2_val = b; in_imm = imm; in_use_imm = use_imm; in_rd = rd; in_wen = wen;
    endtask

    task automatic test_reset();
        rst_n = 0;
        set_idle();
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (out_op !== 3'd2) begin errors++; $display("FAIL rst_op got=%0d exp=2", out_op); end
        checks++; if (out_a !== 32'd0 || out_b !== 32'd0) begin errors++; $display("FAIL rst_ab got=%h/%h exp=0/0", out_a, out_b); end
        checks++; if (out_rd !== 5'd0 || out_wen !== 1'b0) begin errors++; $display("FAIL rst_rd_wen got=%0d/%b exp=0/0", out_rd, out_wen); end
        @(negedge clk); rst_n = 1;
        tick();
        present(3'd6, 5'd1, 5'd2, 32'h55, 32'h66, 32'h0, 1'b0, 5'd7, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b1 || out_a !== 32'h55) begin errors++; $display("FAIL rst_precap got=%b/%h exp=1/00000055", out_valid, out_a); end
        #2 rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_wen !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b/%b exp=0/0", out_valid, out_wen); end
        checks++; if (out_a !== 32'd0 || out_b !== 32'd0 || out_rd !== 5'd0 || out_op !== 3'd2) begin errors++; $display("FAIL rst_async_data got=%h/%h/%0d/%0d exp=0/0/0/2", out_a, out_b, out_rd, out_op); end
        in_valid = 0;
        @(negedge clk); rst_n = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
        $display("reset: async clear and release done");
        tick();
    endtask

    task automatic test_streaming();
        logic [2:0]  ops [4];
        logic [31:0] exp_b;
        ops[0] = 3'd2; ops[1] = 3'd6; ops[2] = 3'd0; ops[3] = 3'd7;
        set_idle();
        for (int k = 0; k < 4; k++) begin
            present(ops[k], 5'd1, 5'd2, 32'h100 + k, 32'h200 + k, 32'hFFFF_FFF0,
                    (k == 2), 5'(20 + k), 1'b1);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
            tick();
            exp_b = (k == 2) ? 32'hFFFF_FFF0 : 32'h200 + k;
            checks++; if (out_valid !== 1'b1 || out_wen !== 1'b1 || out_op !== ops[k] || out_rd !== 5'(20 + k))
                begin errors++; $display("FAIL stream_ctl k=%0d got=%b/%b/%0d/%0d exp=1/1/%0d/%0d", k, out_valid, out_wen, out_op, out_rd, ops[k], 20 + k); end
            checks++; if (out_a !== 32'h100 + k || out_b !== exp_b)
                begin errors++; $display("FAIL stream_ops k=%0d got=%h/%h exp=%h/%h", k, out_a, out_b, 32'h100 + k, exp_b); end
            $display("stream: instr %0d op=%0d a=%h b=%h rd=%0d", k, out_op, out_a, out_b, out_rd);
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_wen !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b/%b exp=0/0", out_valid, out_wen); end
    endtask

    task automatic test_back_to_back();
        set_idle();
        present(3'd1, 5'd1, 5'd2, 32'hA, 32'hB, 32'h0, 1'b0, 5'd9, 1'b1);
        tick();
        ex_ready = 0;
        present(3'd3, 5'd3, 5'd2, 32'hC, 32'hD, 32'h0, 1'b0, 5'd10, 1'b1);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd9 || out_a !== 32'hA) begin errors++; $display("FAIL hold_keep got=%b/%0d/%h exp=1/9/0000000a", out_valid, out_rd, out_a); end
        ex_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd10 || out_a !== 32'hC || out_op !== 3'd3) begin errors++; $display("FAIL b2b_next got=%b/%0d/%h/%0d exp=1/10/0000000c/3", out_valid, out_rd, out_a, out_op); end
        $display("back_to_back: rd=%0d followed rd=9", out_rd);
        in_valid = 0;
        tick();
    endtask

    task automatic test_flush();
        set_idle();
        present(3'd2, 5'd1, 5'd2, 32'h11, 32'h22, 32'h0, 1'b0, 5'd11, 1'b1);
        tick();
        present(3'd2, 5'd1, 5'd2, 32'h33, 32'h44, 32'h0, 1'b0, 5'd12, 1'b1);
        flush = 1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_wen !== 1'b0) begin errors++; $display("FAIL flush_kill got=%b/%b exp=0/0", out_valid, out_wen); end
        flush = 0; in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_nocap got=%b exp=0", out_valid); end
        $display("flush: entry and concurrent capture dropped");
    endtask

`ifdef ALU_FWD_EN
    task automatic test_forward();
        set_idle();
        present(3'd2, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, 1'b0, 5'd8, 1'b1);
        tick();
        in_valid = 0; ex_ready = 0;
        mem_wen = 1; mem_rd = 5; mem_val = 32'd7; wb_wen = 1; wb_rd = 5; wb_val = 32'd9;
        #1;
        checks++; if (out_a !== 32'd7) begin errors++; $display("FAIL fwd_mem_prio got=%h exp=00000007", out_a); end
        mem_wen = 0;
        #1;
        checks++; if (out_a !== 32'd9) begin errors++; $display("FAIL fwd_wb got=%h exp=00000009", out_a); end
        tick();
        wb_wen = 0;
        #1;
        checks++; if (out_a !== 32'd9 || out_b !== 32'h2) begin errors++; $display("FAIL fwd_retain got=%h/%h exp=00000009/00000002", out_a, out_b); end
        ex_ready = 1;
        tick();
        $display("forward: MEM over WB, WB value retained");
    endtask

    task automatic test_load_use();
        set_idle();
        present(3'd6, 5'd4, 5'd3, 32'h10, 32'h1, 32'h0, 1'b0, 5'd9, 1'b1);
        tick();
        in_valid = 0;
        mem_wen = 1; mem_rd = 3; mem_is_load = 1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_wen !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%b/%b/%b exp=0/0/0", out_valid, in_ready, out_wen); end
        tick();
        mem_wen = 0; mem_is_load = 0; wb_wen = 1; wb_rd = 3; wb_val = 32'h1234;
        #1;
        checks++; if (out_valid !== 1'b1 || out_b !== 32'h1234 || out_a !== 32'h10) begin errors++; $display("FAIL lu_resume got=%b/%h/%h exp=1/00001234/00000010", out_valid, out_b, out_a); end
        tick();
        wb_wen = 0;
        $display("load_use: one bubble then b=%h", 32'h1234);
    endtask
`else
    task automatic test_interlock();
        set_idle();
        ex_ready = 0;
        present(3'd2, 5'd1, 5'd2, 32'h1, 32'h2, 32'h0, 1'b0, 5'd4, 1'b1);
        tick();
        present(3'd2, 5'd4, 5'd2, 32'h44, 32'h2, 32'h0, 1'b0, 5'd5, 1'b1);
        ex_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ilk_out got=%b exp=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ilk_nocap got=%b exp=0", out_valid); end
        mem_wen = 1; mem_rd = 4;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ilk_mem got=%b exp=0", in_ready); end
        tick();
        mem_wen = 0; wb_wen = 1; wb_rd = 4;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ilk_wb got=%b exp=0", in_ready); end
        tick();
        wb_wen = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ilk_release got=%b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_a !== 32'h44 || out_rd !== 5'd5) begin errors++; $display("FAIL ilk_cap got=%b/%h/%0d exp=1/00000044/5", out_valid, out_a, out_rd); end
        present(3'd2, 5'd0, 5'd4, 32'h0, 32'h0, 32'h77, 1'b1, 5'd6, 1'b0);
        mem_wen = 1; mem_rd = 0; wb_wen = 1; wb_rd = 4;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ilk_x0_imm got=%b exp=1", in_ready); end
        in_use_imm = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ilk_rs2 got=%b exp=0", in_ready); end
        in_valid = 0; mem_wen = 0; wb_wen = 0;
        tick();
        $display("interlock: rd 4 blocked through OUT/MEM/WB then released");
    endtask
`endif

    initial begin
        test_reset();
        test_streaming();
        test_back_to_back();
        test_flush();
`ifdef ALU_FWD_EN
        test_forward();
        test_load_use();
`else
        test_interlock();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
